// File: rtl/shared_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the unified memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface shared_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store, with bounded data priority
// so that a run of data accesses cannot starve instruction fetch.
module shared_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_mem_arbiter_if.slave  bus
);
    localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_rvalid_q, d_rvalid_q, d_err_q;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;

    logic fetch_gnt_c;
    logic data_gnt_c;
    logic d_illegal_c;
    logic streak_full_c;

    // Alignment and func3 legality of the pending data access.
    always_comb begin
        d_illegal_c = 1'b0;
        case (bus.d_func3)
            3'd0:    d_illegal_c = 1'b0;
            3'd1:    d_illegal_c = bus.d_addr[0];
            3'd2:    d_illegal_c = |bus.d_addr[1:0];
            3'd4:    d_illegal_c = bus.d_we;
            3'd5:    d_illegal_c = bus.d_we | bus.d_addr[0];
            default: d_illegal_c = 1'b1;
        endcase
    end

    // Grant selection: data preferred until its streak saturates with fetch waiting.
    always_comb begin
        streak_full_c = (streak_q == STREAK_MAX);
        fetch_gnt_c   = rst_n & bus.if_req & (~bus.d_req | streak_full_c);
        data_gnt_c    = rst_n & bus.d_req & ~(bus.if_req & streak_full_c);
    end

    // Memory-side controls; zero whenever nothing is issued so no access can leak.
    always_comb begin
        bus.if_gnt    = fetch_gnt_c;
        bus.d_gnt     = data_gnt_c;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_func3 = 3'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (fetch_gnt_c) begin
            bus.mem_read  = 1'b1;
            bus.mem_func3 = 3'd2;
            bus.mem_addr  = bus.if_addr & ~32'd3;
        end else if (data_gnt_c && !d_illegal_c) begin
            bus.mem_read  = ~bus.d_we;
            bus.mem_write = bus.d_we;
            bus.mem_func3 = bus.d_func3;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (!bus.if_req || fetch_gnt_c) begin
            streak_d = '0;
        end else if (data_gnt_c && !streak_full_c) begin
            streak_d = streak_q + STREAK_W'(1);
        end
        if (fetch_gnt_c) begin
            if_rdata_d = bus.mem_rdata;
        end
        // Stores and rejected accesses answer with zero data.
        if (data_gnt_c) begin
            d_rdata_d = (bus.d_we || d_illegal_c) ? 32'd0 : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            streak_q    <= streak_d;
            if_rvalid_q <= fetch_gnt_c;
            d_rvalid_q  <= data_gnt_c;
            d_err_q     <= data_gnt_c & d_illegal_c;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Arbitrates the single unified instruction/data memory of the pipelined RV32 core between the fetch stage and the memory stage. It issues at most one memory access per cycle and forwards each access's control signals to the memory. Read data comes back to the requester as a registered response. Misaligned data accesses are blocked, and a bounded-priority scheme keeps a stream of loads/stores from starving fetch.

## Interface
- MAX_DATA_STREAK, 2: maximum consecutive data grants while a fetch is pending (≥1).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request valid.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  combinational; request consumed this cycle.
- if_rvalid  out  1  registered; if_rdata valid.
- if_rdata  out  32  registered fetched word.
- d_req  in  1  data request valid.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  RV32 width/sign code (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0/1/2).
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  combinational; data request consumed this cycle.
- d_rvalid  out  1  registered; data response valid (loads and stores).
- d_rdata  out  32  registered load data; 0 for stores and errors.
- d_err  out  1  registered with d_rvalid; misaligned or illegal func3.
- mem_read, mem_write  out  1 each  memory control.
- mem_func3  out  3  width code to memory.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data.

## Operation
- Requests use valid/grant. A requester holds req and its fields stable until its gnt is high. In the cycle after gnt it presents its next request or drops req.
- Grant selection each cycle:
  - Neither port requesting: no grant.
  - One port requesting: that port is granted.
  - Both requesting: data wins, unless streak == MAX_DATA_STREAK; then fetch wins.
- streak counter (width clog2(MAX_DATA_STREAK+1)):
  - +1 on each data grant while if_req=1, saturating at MAX_DATA_STREAK.
  - Cleared on a fetch grant or whenever if_req=0.
- Fetch grant: mem_read=1, mem_write=0, mem_func3=2, mem_addr={if_addr[31:2],2'b00}.
- Data grant, legal access: mem_read=~d_we, mem_write=d_we, mem_func3=d_func3, mem_addr=d_addr, mem_wdata=d_wdata.
- Data is illegal when any of these holds:
  - func3 ∈ {2} and addr[1:0]≠0.
  - func3 ∈ {1,5} and addr[0]=1.
  - Load func3 ∉ {0,1,2,4,5}.
  - Store func3 ∉ {0,1,2}.
- Illegal data grant:
  - d_gnt still asserts and the request is consumed.
  - mem_read=mem_write=0.
  - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
- No grant, or rst_n low: all mem_* outputs are 0.
- Granted fetch: if_rdata ← mem_rdata at the clock edge.
- Granted load: d_rdata ← mem_rdata at the clock edge.
- Granted store: d_rdata ← 0.

## Timing
- Reset values: if_rvalid=0, d_rvalid=0, d_err=0, if_rdata=0, d_rdata=0, streak=0. While rst_n=0, if_gnt=d_gnt=0.
- Asserting rst_n mid-access suppresses the combinational mem_write immediately, so no write commits. Any pending response is discarded.
- gnt and the mem_* outputs are valid in the same cycle N as the request.
- Store commits at the rising edge ending cycle N.
- *_rvalid and response data are high for exactly one cycle, N+1.
- Throughput: one access per cycle total. A lone requester gets back-to-back grants.
- Store then load to the same address in consecutive cycles: the load returns the stored value.
- Fetch and data never both granted in one cycle.

## Test plan
- Reset: hold rst_n=0 with if_req=d_req=1 → no gnt, all mem_* 0, all outputs 0. Release → fetch/data arbitration starts on the next edge.
- Fetch only: if_addr=0x4,0x8,0xC on consecutive cycles → if_gnt every cycle, mem_addr 0x4/0x8/0xC with func3 2. if_rvalid follows each by one cycle with the memory words. if_addr=0x7 → mem_addr 0x4.
- Contention, MAX_DATA_STREAK=2: both req held continuously → grant pattern D,D,F,D,D,F. Drop if_req for one cycle → streak clears.
- Store/load: SW x=0xA5A5_1234 to 0x70, then LW 0x70 → LW d_rdata=0xA5A5_1234. LB 0x70 → 0x0000_0034. LHU 0x72 → 0x0000_A5A5.
- Misaligned: LW at 0x71 → d_gnt=1, mem_read=mem_write=0, next cycle d_rvalid=1, d_err=1, d_rdata=0. SH at 0x73 → memory unchanged, d_err=1.
- Reset mid-store: drop rst_n during a granted SW cycle → memory unchanged, d_rvalid stays 0.
